nrzi_bit_stuffer: RTL and testbench

Transmit line encoder downstream of the PISO serializer in the USB hub. Buffers the serial bit stream (`piso_data_out`/`piso_data_val`/`piso_data_last`), inserts USB stuff bits, NRZI-encodes onto full-speed D+/D- and appends EOP (SE0, SE0, J). One bit per `clk`; a small elastic FIFO absorbs the rate mismatch caused by stuffing, since the serializer has no backpressure.

---
 rtl/nrzi_bit_stuffer_if.sv | 27 ++
 rtl/nrzi_bit_stuffer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_nrzi_bit_stuffer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nrzi_bit_stuffer_if.sv
// Serial-bit input and USB full-speed line output bundle for nrzi_bit_stuffer.
// Ports: piso_data_out/val/last carry the serial bit stream from the serializer.
//        line_dp/dm/oe drive the transceiver; tx_busy/eop_done/tx_overflow/tx_underrun are status.
interface nrzi_bit_stuffer_if;
  logic piso_data_out;
  logic piso_data_val;
  logic piso_data_last;
  logic line_dp;
  logic line_dm;
  logic line_oe;
  logic tx_busy;
  logic eop_done;
  logic tx_overflow;
  logic tx_underrun;

  // Serializer side: produces bits, observes line and status.
  modport master (
    output piso_data_out, piso_data_val, piso_data_last,
    input  line_dp, line_dm, line_oe, tx_busy, eop_done, tx_overflow, tx_underrun
  );

  // Encoder side.
  modport slave (
    input  piso_data_out, piso_data_val, piso_data_last,
    output line_dp, line_dm, line_oe, tx_busy, eop_done, tx_overflow, tx_underrun
  );
endinterface

// File: rtl/nrzi_bit_stuffer.sv
// USB full-speed transmit encoder: elastic bit FIFO, bit stuffing, NRZI and EOP.
// Latency: a bit pushed in cycle k can appear on the line in cycle k+2 (all outputs registered).
// Backpressure: none upstream; stuffing slack is absorbed by the FIFO, a push into a full FIFO
// without a concurrent pop drops the bit and sets sticky tx_overflow.
// Ports: clk, rst (sync, active low), bus (slave modport of nrzi_bit_stuffer_if).
module nrzi_bit_stuffer #(
  parameter int FIFO_DEPTH  = 16,
  parameter int START_LEVEL = 4
) (
  input logic              clk,
  input logic              rst,
  nrzi_bit_stuffer_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    STUFF = 3'd2,
    SE0_1 = 3'd3,
    SE0_2 = 3'd4,
    EOP_J = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // Bit FIFO: entry = {bit, last}
  // ---------------------------------------------------------------------------
  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  // Number of queued entries flagged last; lets a short packet start below START_LEVEL.
  logic [CW-1:0] last_cnt;

  logic fifo_empty;
  logic fifo_full;
  logic head_bit;
  logic head_last;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign head_bit   = mem[rd_ptr][1];
  assign head_last  = mem[rd_ptr][0];

  // ---------------------------------------------------------------------------
  // Encoder state. The registered state is the symbol currently on the line;
  // an entry is popped on the transition into the DATA symbol that carries it.
  // ---------------------------------------------------------------------------
  state_t     state;
  state_t     state_n;
  logic       jk;         // 1 = J
  logic       jk_n;
  logic [2:0] ones_cnt;
  logic [2:0] ones_n;
  logic       last_sent;  // current DATA symbol (or the stuff after it) closed the packet
  logic       last_n;
  logic       discard;
  logic       discard_n;
  logic       overflow;
  logic       underrun;

  logic       pop;
  logic       want_pop;
  logic       underrun_set;
  logic       drop_in;
  logic       push;
  logic       overflow_set;

  // Registered line/status outputs
  logic dp_q, dm_q, oe_q, busy_q, eop_q;
  logic dp_n, dm_n, oe_n, eop_n;

  // ---------------------------------------------------------------------------
  // Next-state / pop decision
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n      = state;
    jk_n         = jk;
    ones_n       = ones_cnt;
    last_n       = last_sent;
    want_pop     = 1'b0;
    underrun_set = 1'b0;

    case (state)
      IDLE: begin
        jk_n   = 1'b1;
        ones_n = '0;
        last_n = 1'b0;
        if ((count >= CW'(START_LEVEL)) || (last_cnt != '0)) begin
          want_pop = 1'b1;
        end
      end

      DATA: begin
        // Six consecutive ones always get their stuff bit, even after the last data bit.
        if (ones_cnt == 3'd6) begin
          state_n = STUFF;
          jk_n    = ~jk;
          ones_n  = '0;
        end else if (last_sent) begin
          state_n = SE0_1;
        end else if (!fifo_empty) begin
          want_pop = 1'b1;
        end else begin
          underrun_set = 1'b1;
          state_n      = SE0_1;
        end
      end

      STUFF: begin
        if (last_sent) begin
          state_n = SE0_1;
        end else if (!fifo_empty) begin
          want_pop = 1'b1;
        end else begin
          underrun_set = 1'b1;
          state_n      = SE0_1;
        end
      end

      SE0_1: state_n = SE0_2;
      SE0_2: state_n = EOP_J;

      EOP_J: begin
        state_n = IDLE;
        jk_n    = 1'b1;
        ones_n  = '0;
      end

      default: begin
        state_n = IDLE;
        jk_n    = 1'b1;
        ones_n  = '0;
      end
    endcase

    // Popping the head entry: NRZI keeps J/K on a 1 and toggles on a 0.
    // ones_n already holds the run length preceding this bit.
    pop = want_pop;
    if (want_pop) begin
      state_n = DATA;
      last_n  = head_last;
      if (head_bit) begin
        ones_n = ones_n + 3'd1;
      end else begin
        jk_n   = ~jk_n;
        ones_n = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Input acceptance. A bit arriving in the underrun cycle belongs to the
  // aborted packet, so it is dropped along with the rest of that packet.
  // ---------------------------------------------------------------------------
  always_comb begin
    drop_in      = discard || underrun_set;
    push         = bus.piso_data_val && !drop_in && (!fifo_full || pop);
    overflow_set = bus.piso_data_val && !drop_in && fifo_full && !pop;

    discard_n = discard;
    if (underrun_set) begin
      discard_n = !(bus.piso_data_val && bus.piso_data_last);
    end else if (discard && bus.piso_data_val && bus.piso_data_last) begin
      discard_n = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Line levels for the next symbol
  // ---------------------------------------------------------------------------
  always_comb begin
    dp_n  = 1'b1;
    dm_n  = 1'b0;
    oe_n  = 1'b0;
    eop_n = 1'b0;
    case (state_n)
      DATA, STUFF: begin
        dp_n = jk_n;
        dm_n = ~jk_n;
        oe_n = 1'b1;
      end
      SE0_1, SE0_2: begin
        dp_n = 1'b0;
        dm_n = 1'b0;
        oe_n = 1'b1;
      end
      EOP_J: begin
        dp_n  = 1'b1;
        dm_n  = 1'b0;
        oe_n  = 1'b1;
        eop_n = 1'b1;
      end
      default: begin
        dp_n = 1'b1;
        dm_n = 1'b0;
        oe_n = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, FIFO bookkeeping and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      jk        <= 1'b1;
      ones_cnt  <= '0;
      last_sent <= 1'b0;
      discard   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_cnt  <= '0;
      overflow  <= 1'b0;
      underrun  <= 1'b0;
      dp_q      <= 1'b1;
      dm_q      <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      state     <= state_n;
      jk        <= jk_n;
      ones_cnt  <= ones_n;
      last_sent <= last_n;
      discard   <= discard_n;

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count    <= count + CW'(push) - CW'(pop);
      last_cnt <= last_cnt + CW'(push && bus.piso_data_last) - CW'(pop && head_last);

      if (overflow_set) begin
        overflow <= 1'b1;
      end
      if (underrun_set) begin
        underrun <= 1'b1;
      end

      dp_q   <= dp_n;
      dm_q   <= dm_n;
      oe_q   <= oe_n;
      busy_q <= (state_n != IDLE);
      eop_q  <= eop_n;
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr] <= {bus.piso_data_out, bus.piso_data_last};
    end
  end

  assign bus.line_dp     = dp_q;
  assign bus.line_dm     = dm_q;
  assign bus.line_oe     = oe_q;
  assign bus.tx_busy     = busy_q;
  assign bus.eop_done    = eop_q;
  assign bus.tx_overflow = overflow;
  assign bus.tx_underrun = underrun;

endmodule

// File: tb/tb_nrzi_bit_stuffer.sv
// Testbench for nrzi_bit_stuffer: three instances (16/4, 8/2, 8/8) share one stimulus
// source; a line monitor compares every driven symbol against a scoreboard queue filled
// by a reference NRZI/stuffing model when each packet is sent.
module tb_nrzi_bit_stuffer;

  logic clk;
  logic rst;
  int   cyc;
  int   sel;

  logic d_bit, d_val, d_last;

  int tests_run;
  int fails;

  nrzi_bit_stuffer_if ifa ();
  nrzi_bit_stuffer_if ifb ();
  nrzi_bit_stuffer_if ifc ();

  assign ifa.piso_data_out  = d_bit;
  assign ifa.piso_data_last = d_last;
  assign ifa.piso_data_val  = d_val && (sel == 0);
  assign ifb.piso_data_out  = d_bit;
  assign ifb.piso_data_last = d_last;
  assign ifb.piso_data_val  = d_val && (sel == 1);
  assign ifc.piso_data_out  = d_bit;
  assign ifc.piso_data_last = d_last;
  assign ifc.piso_data_val  = d_val && (sel == 2);

  nrzi_bit_stuffer #(.FIFO_DEPTH(16), .START_LEVEL(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  nrzi_bit_stuffer #(.FIFO_DEPTH(8),  .START_LEVEL(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  nrzi_bit_stuffer #(.FIFO_DEPTH(8),  .START_LEVEL(8)) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  logic mon_dp, mon_dm, mon_oe, mon_busy, mon_eop, mon_ovf, mon_unr;
  assign mon_dp   = (sel == 0) ? ifa.line_dp     : (sel == 1) ? ifb.line_dp     : ifc.line_dp;
  assign mon_dm   = (sel == 0) ? ifa.line_dm     : (sel == 1) ? ifb.line_dm     : ifc.line_dm;
  assign mon_oe   = (sel == 0) ? ifa.line_oe     : (sel == 1) ? ifb.line_oe     : ifc.line_oe;
  assign mon_busy = (sel == 0) ? ifa.tx_busy     : (sel == 1) ? ifb.tx_busy     : ifc.tx_busy;
  assign mon_eop  = (sel == 0) ? ifa.eop_done    : (sel == 1) ? ifb.eop_done    : ifc.eop_done;
  assign mon_ovf  = (sel == 0) ? ifa.tx_overflow : (sel == 1) ? ifb.tx_overflow : ifc.tx_overflow;
  assign mon_unr  = (sel == 0) ? ifa.tx_underrun : (sel == 1) ? ifb.tx_underrun : ifc.tx_underrun;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Packet buffer and push timestamps
  logic pkt      [0:127];
  logic pkt_last [0:127];
  int   push_cyc [0:127];
  int   exp_stuff;

  // Scoreboard: {dp, dm, eop_done} per driven line cycle
  logic [2:0] exp_q [$];

  // Monitor state
  logic mon_en;
  logic prev_oe, prev_eop;
  int   first_oe_cyc;
  int   run_len;
  int   last_pkt_cycles;

  always @(negedge clk) begin
    logic [2:0] got;
    logic [2:0] exp;
    if (mon_en && rst) begin
      if (prev_eop) begin
        tests_run++;
        if (mon_oe !== 1'b0) begin
          fails++;
          $display("FAIL oe_after_eop: line_oe=%b required 0 (cycle %0d)", mon_oe, cyc);
        end
      end
      if (mon_oe) begin
        if (!prev_oe) begin
          first_oe_cyc = cyc;
          run_len      = 0;
        end
        run_len++;
        got = {mon_dp, mon_dm, mon_eop};
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL line_symbol: got {dp,dm,eop}=%b, required no driven symbol (cycle %0d)", got, cyc);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            fails++;
            $display("FAIL line_symbol: got {dp,dm,eop}=%b required %b (cycle %0d)", got, exp, cyc);
          end
        end
        if (mon_eop) last_pkt_cycles = run_len;
      end else if (prev_oe) begin
        tests_run++;
        if (!prev_eop) begin
          fails++;
          $display("FAIL line_gap: line_oe dropped before EOP J, required contiguous symbols (cycle %0d)", cyc);
        end
      end
      prev_oe  = mon_oe;
      prev_eop = mon_eop;
    end else begin
      prev_oe  = 1'b0;
      prev_eop = 1'b0;
    end
  end

  // Reference encoder: NRZI from J, a K/J flip after every six ones, then SE0 SE0 J.
  task automatic queue_expected(input int lo, input int hi);
    logic jk;
    int   ones;
    jk = 1'b1;
    ones = 0;
    exp_stuff = 0;
    for (int i = lo; i <= hi; i++) begin
      if (pkt[i]) ones++;
      else begin
        jk = ~jk;
        ones = 0;
      end
      exp_q.push_back({jk, ~jk, 1'b0});
      if (ones == 6) begin
        jk = ~jk;
        ones = 0;
        exp_stuff++;
        exp_q.push_back({jk, ~jk, 1'b0});
      end
    end
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b101);
  endtask

  task automatic send_bits(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      d_bit  = pkt[i];
      d_last = pkt_last[i];
      d_val  = 1'b1;
      push_cyc[i] = cyc;
    end
    @(negedge clk);
    d_val  = 1'b0;
    d_last = 1'b0;
  endtask

  task automatic set_bits(input int lo, input int n, input logic [63:0] val, input bit last_at_end);
    logic [63:0] v;
    v = val;
    for (int i = 0; i < n; i++) begin
      pkt[lo + i]      = v[i];
      pkt_last[lo + i] = last_at_end && (i == n - 1);
    end
  endtask

  task automatic wait_idle(input int budget, input string what);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || mon_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    tests_run++;
    if (k >= budget) begin
      fails++;
      $display("FAIL %s_timeout: %0d symbols still pending, tx_busy=%b, required drained within %0d cycles",
               what, exp_q.size(), mon_busy, budget);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_pkt_len(input string what, input int n);
    tests_run++;
    if (last_pkt_cycles !== n + exp_stuff + 3) begin
      fails++;
      $display("FAIL %s_len: %0d driven cycles, required %0d", what, last_pkt_cycles, n + exp_stuff + 3);
    end
  endtask

  task automatic test_reset;
    logic [6:0] got;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      got = {mon_dp, mon_dm, mon_oe, mon_busy, mon_eop, mon_ovf, mon_unr};
      tests_run++;
      if (got !== 7'b1000000) begin
        fails++;
        $display("FAIL reset_outputs_%0d: {dp,dm,oe,busy,eop,ovf,unr}=%b required 1000000", s, got);
      end
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte;
    sel = 0;
    set_bits(0, 8, 64'h00, 1'b1);
    queue_expected(0, 7);
    send_bits(0, 7);
    wait_idle(100, "single_byte");
    tests_run++;
    if (first_oe_cyc !== push_cyc[3] + 2) begin
      fails++;
      $display("FAIL single_byte_latency: first line cycle %0d, required %0d", first_oe_cyc, push_cyc[3] + 2);
    end
    check_pkt_len("single_byte", 8);
  endtask

  task automatic test_eight_ones;
    sel = 0;
    set_bits(0, 8, 64'hFF, 1'b1);
    queue_expected(0, 7);
    send_bits(0, 7);
    wait_idle(100, "eight_ones");
    check_pkt_len("eight_ones", 8);
  endtask

  task automatic test_six_ones_last;
    sel = 0;
    set_bits(0, 8, 64'hFC, 1'b1);
    queue_expected(0, 7);
    send_bits(0, 7);
    wait_idle(100, "six_ones_last");
    check_pkt_len("six_ones_last", 8);
    // The following packet starts with five ones: a leaked run count would stuff early.
    set_bits(0, 8, 64'h5F, 1'b1);
    queue_expected(0, 7);
    send_bits(0, 7);
    wait_idle(100, "after_six_ones");
    check_pkt_len("after_six_ones", 8);
  endtask

  task automatic test_back_to_back;
    sel = 0;
    set_bits(0, 12, 64'hEB7, 1'b1);
    for (int i = 12; i < 22; i++) begin
      pkt[i]      = 1'($urandom_range(0, 1));
      pkt_last[i] = (i == 21);
    end
    queue_expected(0, 11);
    queue_expected(12, 21);
    send_bits(0, 21);
    wait_idle(200, "back_to_back");
    check_pkt_len("back_to_back_second", 10);
  endtask

  task automatic test_long_ones;
    sel = 1;
    for (int i = 0; i < 40; i++) begin
      pkt[i]      = 1'b1;
      pkt_last[i] = (i == 39);
    end
    queue_expected(0, 39);
    send_bits(0, 39);
    wait_idle(200, "long_ones");
    check_pkt_len("long_ones", 40);
    tests_run++;
    if (mon_ovf !== 1'b0) begin
      fails++;
      $display("FAIL long_ones_overflow: tx_overflow=%b required 0", mon_ovf);
    end
  endtask

  task automatic test_overflow;
    int ovf_cyc;
    int k;
    sel = 2;
    mon_en = 1'b0;
    ovf_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ovf_cyc < 0 && mon_ovf) ovf_cyc = cyc;
      d_bit  = 1'b1;
      d_last = (i == 59);
      d_val  = 1'b1;
      push_cyc[i] = cyc;
    end
    @(negedge clk);
    d_val  = 1'b0;
    d_last = 1'b0;
    // Pop starts with the 8th entry; the first stuff cycle meets a full FIFO with no pop.
    tests_run++;
    if (ovf_cyc !== push_cyc[0] + 15) begin
      fails++;
      $display("FAIL overflow_cycle: tx_overflow first seen cycle %0d, required %0d", ovf_cyc, push_cyc[0] + 15);
    end
    k = 0;
    while (mon_busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    tests_run++;
    if (mon_busy !== 1'b0 || mon_ovf !== 1'b1) begin
      fails++;
      $display("FAIL overflow_end: tx_busy=%b tx_overflow=%b, required 0 and 1", mon_busy, mon_ovf);
    end
    sel = 0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_underrun;
    sel = 0;
    tests_run++;
    if (mon_unr !== 1'b0) begin
      fails++;
      $display("FAIL underrun_pre: tx_underrun=%b required 0", mon_unr);
    end
    set_bits(0, 16, 64'h3CA5, 1'b0);
    set_bits(16, 8, 64'h96, 1'b1);
    queue_expected(0, 15);
    send_bits(0, 15);
    repeat (10) @(negedge clk);
    tests_run++;
    if (mon_unr !== 1'b1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL underrun_abort: tx_underrun=%b pending=%0d, required 1 and 0", mon_unr, exp_q.size());
    end
    // Aborted packet: 16 data symbols, then SE0 right after the empty-FIFO cycle.
    check_pkt_len("underrun", 16);
    send_bits(16, 23);
    repeat (20) @(negedge clk);
    tests_run++;
    if (mon_busy !== 1'b0) begin
      fails++;
      $display("FAIL underrun_discard: tx_busy=%b required 0 after discarded tail", mon_busy);
    end
    set_bits(0, 8, 64'h2D, 1'b1);
    queue_expected(0, 7);
    send_bits(0, 7);
    wait_idle(100, "after_underrun");
    check_pkt_len("after_underrun", 8);
  endtask

  task automatic test_reset_mid;
    logic [5:0] got;
    sel = 0;
    mon_en = 1'b0;
    set_bits(0, 12, 64'h5A5, 1'b0);
    send_bits(0, 9);
    tests_run++;
    if (mon_busy !== 1'b1 || mon_oe !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pre: tx_busy=%b line_oe=%b required 1 and 1", mon_busy, mon_oe);
    end
    rst = 1'b0;
    @(negedge clk);
    got = {mon_dp, mon_dm, mon_oe, mon_busy, mon_ovf, mon_unr};
    tests_run++;
    if (got !== 6'b100000) begin
      fails++;
      $display("FAIL reset_mid: {dp,dm,oe,busy,ovf,unr}=%b required 100000", got);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    set_bits(0, 8, 64'h01, 1'b1);
    queue_expected(0, 7);
    send_bits(0, 7);
    wait_idle(100, "after_reset");
    check_pkt_len("after_reset", 8);
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    rst = 1'b0;
    sel = 0;
    d_bit = 1'b0;
    d_val = 1'b0;
    d_last = 1'b0;
    mon_en = 1'b0;
    first_oe_cyc = -1;
    run_len = 0;
    last_pkt_cycles = -1;
    exp_stuff = 0;

    test_reset();
    mon_en = 1'b1;
    test_single_byte();
    test_eight_ones();
    test_six_ones_last();
    test_back_to_back();
    test_long_ones();
    test_overflow();
    test_underrun();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion within 50000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
